rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 38 +++
 rtl/rf_write_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared defaults and state type for the register-file write arbiter.
package rf_arb_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int NREGS  = 2**AW_DEF;

    typedef enum logic {CLEAR, ARB} state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; grants are combinational.
import rf_arb_pkg::*;

module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_v0,
    input  logic i_v1,
    output logic o_g0,
    output logic o_g1
);
    logic r_last;

    // Under contention the requester not granted most recently wins.
    always_comb begin
        o_g0 = 1'b0;
        o_g1 = 1'b0;
        if (i_en) begin
            if (i_v0 && i_v1) begin
                o_g0 = r_last;
                o_g1 = !r_last;
            end else begin
                o_g0 = i_v0;
                o_g1 = i_v1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (o_g0)
            r_last <= 1'b0;
        else if (o_g1)
            r_last <= 1'b1;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two register-file write requesters onto one registered write port.
// Optional macro RF_CLEAR_EN: zero every register after reset before arbitration starts.
import rf_arb_pkg::*;

module rf_write_arbiter #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_wn,
    input  logic [DW-1:0] req0_wd,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_wn,
    input  logic [DW-1:0] req1_wd,
    output logic          req1_ready,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_wd,
    output logic          rf_w,
    output logic          busy
);
    logic          w_arb_en;
    logic          w_g0;
    logic          w_g1;
    logic          r_w;
    logic [AW-1:0] r_wn;
    logic [DW-1:0] r_wd;

`ifdef RF_CLEAR_EN
    state_e        r_state;
    logic [AW:0]   r_cnt;

    assign w_arb_en = rst_n && (r_state == ARB);
    assign busy     = (r_state == CLEAR);
`else
    assign w_arb_en = rst_n;
    assign busy     = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_arb_en),
        .i_v0  (req0_valid),
        .i_v1  (req1_valid),
        .o_g0  (w_g0),
        .o_g1  (w_g1)
    );

    assign req0_ready = w_g0;
    assign req1_ready = w_g1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w  <= 1'b0;
            r_wn <= '0;
            r_wd <= '0;
`ifdef RF_CLEAR_EN
            r_state <= CLEAR;
            r_cnt   <= '0;
`endif
        end
`ifdef RF_CLEAR_EN
        // Counter MSB marks the sweep done; one extra cycle keeps busy up while the last write shows.
        else if (r_state == CLEAR) begin
            if (!r_cnt[AW]) begin
                r_w   <= 1'b1;
                r_wn  <= r_cnt[AW-1:0];
                r_wd  <= '0;
                r_cnt <= r_cnt + (AW+1)'(1);
            end else begin
                r_w     <= 1'b0;
                r_state <= ARB;
            end
        end
`endif
        else begin
            r_w <= w_g0 | w_g1;
            if (w_g0) begin
                r_wn <= req0_wn;
                r_wd <= req0_wd;
            end else if (w_g1) begin
                r_wn <= req1_wn;
                r_wd <= req1_wd;
            end
        end
    end

    assign rf_w  = r_w;
    assign rf_wn = r_wn;
    assign rf_wd = r_wd;
endmodule
